// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Request is held until ack; rdata is sampled with ack.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        output be,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        input  be,
        output ack,
        output rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I memory-stage load/store unit: classifies the request, runs one
// req/ack bus transaction with timeout, and returns extended load data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_wr,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [2:0]         req_memop,
    output logic               req_ready,
    mem_access_unit_if.master  bus,
    output logic               resp_valid,
    output logic [31:0]        resp_data,
    output logic               resp_err,
    output logic               stall
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  wait_q;
    logic [7:0]  wait_d;
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic [31:0] wdata_q;
    logic [31:0] wdata_d;
    logic [3:0]  be_q;
    logic [3:0]  be_d;
    logic        wr_q;
    logic        wr_d;
    logic [2:0]  memop_q;
    logic [2:0]  memop_d;
    logic        err_q;
    logic        err_d;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    logic        illegal;
    logic        misaligned;
    logic        timeout;
    logic [3:0]  be_req;
    logic [31:0] wdata_req;
    logic [31:0] shifted;
    logic [31:0] rdata_ext;

    // Request classification and lane formatting, evaluated in IDLE.
    always_comb begin
        illegal    = (req_memop == 3'b011)
                   || (req_memop[2:1] == 2'b11)
                   || (req_wr && req_memop[2]);
        misaligned = ((req_memop[1:0] == 2'b01) && req_addr[0])
                   || ((req_memop[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        case (req_memop[1:0])
            2'b00: begin
                be_req    = 4'b0001 << req_addr[1:0];
                wdata_req = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_req    = 4'b0011 << {req_addr[1], 1'b0};
                wdata_req = {2{req_wdata[15:0]}};
            end
            default: begin
                be_req    = 4'b1111;
                wdata_req = req_wdata;
            end
        endcase
    end

    // Aligned accesses let one byte-granular shift serve B, H and W.
    always_comb begin
        shifted = bus.rdata >> {addr_q[1:0], 3'b000};
        case (memop_q)
            3'b000:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  rdata_ext = {24'd0, shifted[7:0]};
            3'b001:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  rdata_ext = {16'd0, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

    assign timeout = (wait_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        memop_d = memop_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (illegal || misaligned) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = BUS;
                        wait_d  = 8'd0;
                        addr_d  = req_addr;
                        wdata_d = wdata_req;
                        be_d    = be_req;
                        wr_d    = req_wr;
                        memop_d = req_memop;
                    end
                end
            end
            BUS: begin
                if (bus.ack) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? 32'd0 : rdata_ext;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            wr_q    <= 1'b0;
            memop_q <= 3'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            memop_q <= memop_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus strobes follow the state so reset drops them immediately.
    assign bus.req   = (state_q == BUS);
    assign bus.we    = (state_q == BUS) && wr_q;
    assign bus.be    = (state_q == BUS) ? be_q : 4'd0;
    assign bus.addr  = {addr_q[31:2], 2'b00};
    assign bus.wdata = wdata_q;

    assign req_ready  = (state_q == IDLE);
    assign stall      = (state_q != IDLE) || req_valid;
    assign resp_valid = (state_q == RESP);
    assign resp_data  = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan steps plus random operations
// checked against an arithmetic reference model.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_memop;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        stall;

    int vectors = 0;
    int miss = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_memop  (req_memop),
        .req_ready  (req_ready),
        .bus        (bus),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic void model(
        input  logic        wr,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [2:0]  op,
        input  logic [31:0] rd,
        input  int          dly,
        output logic        err,
        output logic [3:0]  be,
        output logic [31:0] bwd,
        output logic [31:0] data,
        output int          lat
    );
        int          sz = 1 << op[1:0];
        int          off = int'(a % 4);
        bit          legal;
        logic [31:0] mask;
        legal = wr ? (op <= 3'd2)
                   : (op <= 3'd2 || op == 3'd4 || op == 3'd5);
        mask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        be   = 4'(((1 << sz) - 1) << off);
        if (sz == 1)      bwd = 32'(wd[7:0]) * 32'h0101_0101;
        else if (sz == 2) bwd = 32'(wd[15:0]) * 32'h0001_0001;
        else              bwd = wd;
        if (!legal || (off % sz) != 0) begin
            err = 1'b1; data = 32'd0; lat = 1;
        end else if (dly < 0 || dly >= TO) begin
            err = 1'b1; data = 32'd0; lat = TO + 1;
        end else begin
            err = 1'b0;
            lat = dly + 2;
            if (wr) begin
                data = 32'd0;
            end else begin
                data = (rd >> (8 * off)) & mask;
                if (!op[2] && sz < 4 && data[8 * sz - 1]) data = data | ~mask;
            end
        end
    endfunction

    // dly = idle BUS cycles before ack; negative means never ack.
    task automatic run_op(input string tag, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] op, input logic [31:0] rd,
                          input int dly);
        logic        e_err;
        logic [3:0]  e_be;
        logic [31:0] e_bwd;
        logic [31:0] e_data;
        int          lat;
        model(wr, a, wd, op, rd, dly, e_err, e_be, e_bwd, e_data, lat);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = wd;
        req_memop = op;
        @(negedge clk);
        chk({tag, ":ready"}, 32'(req_ready), 32'd1);
        chk({tag, ":stall_req"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            chk({tag, ":resp_valid"}, 32'(resp_valid), 32'(n == lat));
            chk({tag, ":bus_req"}, 32'(bus.req), 32'(n < lat));
            chk({tag, ":stall"}, 32'(stall), 32'd1);
            if (n < lat) begin
                chk({tag, ":bus_addr"}, bus.addr, {a[31:2], 2'b00});
                chk({tag, ":bus_be"}, 32'(bus.be), 32'(e_be));
                chk({tag, ":bus_we"}, 32'(bus.we), 32'(wr));
                if (wr) chk({tag, ":bus_wdata"}, bus.wdata, e_bwd);
            end else begin
                chk({tag, ":resp_err"}, 32'(resp_err), 32'(e_err));
                chk({tag, ":resp_data"}, resp_data, e_data);
            end
            if (n < lat && dly >= 0 && n - 1 == dly) begin
                bus.ack   = 1'b1;
                bus.rdata = rd;
            end else begin
                bus.ack   = 1'b0;
                bus.rdata = $urandom;
            end
        end
        @(negedge clk);
        chk({tag, ":resp_drop"}, 32'(resp_valid), 32'd0);
        chk({tag, ":idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ":idle_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_memop = 3'd0;
        bus.ack   = 1'b0;
        bus.rdata = 32'd0;
        #12;
        chk("rst:ready", 32'(req_ready), 32'd1);
        chk("rst:bus_req", 32'(bus.req), 32'd0);
        chk("rst:bus_be", 32'(bus.be), 32'd0);
        chk("rst:bus_addr", bus.addr, 32'd0);
        chk("rst:bus_wdata", bus.wdata, 32'd0);
        chk("rst:resp_valid", 32'(resp_valid), 32'd0);
        chk("rst:resp_data", resp_data, 32'd0);
        chk("rst:resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("lw", 1'b0, 32'h0000_1004, 32'd0, 3'b010, 32'hDEAD_BEEF, 0);
        run_op("lb", 1'b0, 32'h0000_2003, 32'd0, 3'b000, 32'h80FF_0000, 0);
        run_op("lbu", 1'b0, 32'h0000_2003, 32'd0, 3'b100, 32'h80FF_0000, 0);
        run_op("sh", 1'b1, 32'h0000_3002, 32'h1234_ABCD, 3'b001, 32'd0, 3);
        run_op("lw_mis", 1'b0, 32'h0000_1001, 32'd0, 3'b010, 32'd0, 0);
        run_op("op011", 1'b0, 32'h0000_1000, 32'd0, 3'b011, 32'd0, 0);
        run_op("sbu_ill", 1'b1, 32'h0000_1000, 32'd5, 3'b100, 32'd0, 0);
        run_op("tmo", 1'b0, 32'h0000_5000, 32'd0, 3'b010, 32'h1111_1111, -1);

        bus.ack   = 1'b1;
        bus.rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("late_ack:resp_valid", 32'(resp_valid), 32'd0);
        chk("late_ack:bus_req", 32'(bus.req), 32'd0);
        bus.ack = 1'b0;

        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'h0000_4000;
        req_memop = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid:bus_req_pre", 32'(bus.req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid:bus_req", 32'(bus.req), 32'd0);
        chk("rstmid:ready", 32'(req_ready), 32'd1);
        chk("rstmid:resp_valid", 32'(resp_valid), 32'd0);
        chk("rstmid:bus_addr", bus.addr, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        bus.ack   = 1'b1;
        bus.rdata = 32'h1234_5678;
        @(negedge clk);
        bus.ack = 1'b0;
        chk("rstmid:stale_ack", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("rstmid:stale_ack2", 32'(resp_valid), 32'd0);
        run_op("lhu", 1'b0, 32'h0000_0002, 32'd0, 3'b101, 32'hFFFF_0000, 0);

        for (int i = 0; i < 60; i++) begin
            run_op("rnd", 1'($urandom), $urandom, $urandom,
                   3'($urandom_range(0, 7)), $urandom,
                   int'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store unit for the RV32I core. It sits directly downstream of execute and feeds writeback.
- Takes the execute result as the effective address, plus rs2 store data, MemWr and MemOP.
- Runs a request/acknowledge transaction on a variable-latency data-memory bus.
- Returns sign- or zero-extended load data and a stall signal that holds the PC until the access completes.

Parameters:
TIMEOUT, 16, bus cycles to wait for bus_ack before aborting with an error (valid range 1..255).

Ports:
clk  in  1  core clock, all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  execute presents a memory operation this cycle
req_wr  in  1  1 = store, 0 = load (MemWr)
req_addr  in  32  effective byte address (execute result)
req_wdata  in  32  store data (rs2 value)
req_memop  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_ready  out  1  unit can accept a request (state IDLE)
bus_req  out  1  data-bus request, held until acknowledged
bus_we  out  1  bus write enable
bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata  out  32  store data lane-replicated
bus_be  out  4  byte enables
bus_ack  in  1  bus completes the transaction this cycle
bus_rdata  in  32  read data, valid with bus_ack
resp_valid  out  1  one-cycle completion pulse toward writeback
resp_data  out  32  extended load data (0 for stores and errors)
resp_err  out  1  with resp_valid: misaligned, illegal MemOP, or bus timeout
stall  out  1  hold PC and upstream stages

Behaviour:
- Reset (asynchronous, any state including mid-transaction):
  - State goes to IDLE immediately.
  - bus_req, bus_we, bus_be, resp_valid, resp_err = 0; resp_data, bus_addr, bus_wdata = 0.
  - A pending bus transaction is abandoned; a later bus_ack for it is ignored.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, classify the request:
    - Illegal MemOP: 011, 110, 111, or a store with 100/101.
    - Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0.
    - An illegal or misaligned request goes to RESP with resp_err = 1 and issues no bus cycle.
    - Otherwise latch addr, wdata, memop and wr, then go to BUS.
- BUS:
  - bus_req = 1 with all bus outputs stable until bus_ack.
  - On bus_ack, capture and extend bus_rdata (loads), then go to RESP.
  - A wait counter increments each BUS cycle without ack. When it reaches TIMEOUT, go to RESP with resp_err = 1 and resp_data = 0.
- RESP: resp_valid = 1 for exactly one cycle, then go to IDLE. resp_data and resp_err are registered and valid only while resp_valid = 1.
- Latency: request accepted in cycle T → BUS from T+1; bus_ack in cycle T+k → resp_valid in cycle T+k+1. Minimum is 2 cycles, with ack in the first BUS cycle.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 << {addr[1],1'b0}.
  - W: 4'b1111.
  - Loads drive bus_be as for stores; the bus may ignore it.
- Store data: B replicates wdata[7:0] into all four lanes; H replicates wdata[15:0] into both halves; W passes wdata through unchanged.
- Load extraction:
  - The selected byte/half is chosen by addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
- stall = (state != IDLE) || req_valid, asserted combinationally in the request cycle. The core advances on the cycle where resp_valid = 1.
- req_valid while not IDLE is ignored; the upstream stage holds the request because stall = 1.
- bus_ack outside BUS is ignored.

Test Plan:
- Load-word: LW addr 0x0000_1004, bus_ack on first BUS cycle with rdata 0xDEAD_BEEF → bus_addr 0x1004, bus_be 4'b1111, resp_valid 2 cycles after accept, resp_data 0xDEAD_BEEF, resp_err 0.
- Byte loads: LB and LBU at addr 0x2003, rdata 0x80FF_0000 → bus_be 4'b1000; LB gives 0xFFFF_FF80; LBU gives 0x0000_0080.
- Store-half: SH addr 0x3002, wdata 0x1234_ABCD, bus_ack after 3 wait cycles → bus_we 1, bus_be 4'b1100, bus_wdata 0xABCD_ABCD, resp_valid 5 cycles after accept, resp_data 0.
- Misaligned and illegal requests: LW at 0x1001 → no bus_req, resp_valid with resp_err 1 in the second cycle. Likewise memop 3'b011 → resp_err 1.
- Timeout: TIMEOUT = 4, no bus_ack → bus_req high for 4 cycles, then resp_valid with resp_err 1 and resp_data 0. A late bus_ack is ignored.
- Reset mid-transaction: assert rst during BUS wait → bus_req drops asynchronously, state IDLE, req_ready 1, no resp_valid. A following LHU at 0x0002 with rdata 0xFFFF_0000 returns 0x0000_FFFF.
